// File: rtl/keypad_scanner.sv
// keypad_scanner -- 4x4 matrix keypad scanner with frame-based debounce.
//
// Drives one column low at a time (SCAN_DIV cycles each), samples the rows
// on the last cycle of each column's dwell, folds the lowest pressed code of
// a full 4-column frame into a frame result, and debounces that result so
// KEY only changes after DEBOUNCE consecutive agreeing frames.
//
// Ports
//   CK         in   system clock, rising edge
//   RST_N      in   asynchronous active-low reset
//   ROW[3:0]   in   row lines, active-low (pulled up externally)
//   COL[3:0]   out  column drive, active-low, exactly one bit low
//   KEY[7:0]   out  debounced key code 1..16, 0 = no key
//   KEY_EVENT  out  high while KEY != 0
//   PRESS      out  one-cycle pulse when KEY changes to a nonzero code
module keypad_scanner #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic       CK,
  input  logic       RST_N,
  input  logic [3:0] ROW,
  output logic [3:0] COL,
  output logic [7:0] KEY,
  output logic       KEY_EVENT,
  output logic       PRESS
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [1:0]    col_q, col_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [4:0]    frame_q, frame_d;   // lowest code seen so far this frame
  logic [4:0]    cand_q, cand_d;     // debounce candidate
  logic [3:0]    cnt_q, cnt_d;       // agreeing-frame count
  logic [4:0]    key_q, key_d;
  logic          evt_q, evt_d;
  logic          press_q, press_d;

  logic          sample;
  logic [4:0]    col_code, prior, merged;

  assign sample = (dwell_q == DW'(SCAN_DIV - 1));

  // Lowest row wins within a column; codes are 4*r + c + 1.
  always_comb begin
    col_code = 5'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!ROW[r]) col_code = 5'(4 * r + int'(col_q) + 1);
    end
  end

  // Column 0 starts a new frame, so it ignores whatever frame_q holds.
  always_comb begin
    prior  = (col_q == 2'd0) ? 5'd0 : frame_q;
    merged = prior;
    if (col_code != 5'd0 && (prior == 5'd0 || col_code < prior)) merged = col_code;
  end

  always_comb begin
    col_d   = col_q;
    dwell_d = dwell_q + DW'(1);
    frame_d = frame_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    if (sample) begin
      dwell_d = '0;
      col_d   = col_q + 2'd1;        // wraps 3 -> 0 with no idle cycle
      frame_d = merged;
      if (col_q == 2'd3) begin
        frame_d = 5'd0;
        if (merged == cand_q) begin
          if (cnt_q < 4'(DEBOUNCE)) cnt_d = cnt_q + 4'd1;
        end else begin
          cand_d = merged;
          cnt_d  = 4'd1;
        end
      end
    end
  end

  // KEY follows the candidate once it has been stable long enough; the
  // event and press flags are registered alongside so all move together.
  always_comb begin
    key_d   = key_q;
    evt_d   = evt_q;
    press_d = 1'b0;
    if (cnt_q == 4'(DEBOUNCE) && key_q != cand_q) begin
      key_d   = cand_q;
      evt_d   = (cand_q != 5'd0);
      press_d = (cand_q != 5'd0);
    end
  end

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      col_q   <= 2'd0;
      dwell_q <= '0;
      frame_q <= 5'd0;
      cand_q  <= 5'd0;
      cnt_q   <= 4'd0;
      key_q   <= 5'd0;
      evt_q   <= 1'b0;
      press_q <= 1'b0;
    end else begin
      col_q   <= col_d;
      dwell_q <= dwell_d;
      frame_q <= frame_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      evt_q   <= evt_d;
      press_q <= press_d;
    end
  end

  assign COL       = ~(4'b0001 << col_q);
  assign KEY       = {3'b000, key_q};
  assign KEY_EVENT = evt_q;
  assign PRESS     = press_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner (SCAN_DIV=2, DEBOUNCE=2, frame = 8 cycles).
// Stimulus pushes the expected sequence of KEY values; a monitor pops one
// entry on every KEY change and checks PRESS/KEY_EVENT alongside. A scan
// checker watches COL continuously.
module tb_keypad_scanner;
  localparam int SD = 2;
  localparam int DB = 2;

  logic       CK, RST_N;
  logic [3:0] ROW, COL;
  logic [7:0] KEY;
  logic       KEY_EVENT, PRESS;
  logic [15:0] keys;            // bit k-1 set = key code k held

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .CK(CK), .RST_N(RST_N), .ROW(ROW), .COL(COL),
    .KEY(KEY), .KEY_EVENT(KEY_EVENT), .PRESS(PRESS)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Matrix model: a held key at (r,c) pulls ROW[r] low while COL[c] is low.
  always_comb begin
    ROW = 4'hF;
    for (int r = 0; r < 4; r++) ROW[r] = ~|(keys[4*r +: 4] & ~COL);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] kb(input int code);
    logic [15:0] v;
    v = 16'd0;
    v[code-1] = 1'b1;
    return v;
  endfunction

  // Monitor: one expected entry consumed per KEY change.
  logic [7:0] key_prev = 8'd0;
  always @(negedge CK) begin
    chk("key_event", KEY_EVENT, KEY != 8'd0);
    if (KEY !== key_prev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_key_change", KEY, key_prev);
      end else begin
        chk("key_value", KEY, exp_q.pop_front());
        chk("press_on_change", PRESS, KEY != 8'd0);
      end
      key_prev = KEY;
    end else begin
      chk("press_idle", PRESS, 1'b0);
    end
  end

  // Scan checker: one zero bit, rotation order, SCAN_DIV cycles per column.
  logic [3:0] sc_prev = 4'b1110;
  int sc_run = 0;
  bit sc_skip = 1'b1;
  always @(negedge CK) begin
    chk("col_one_low", $countones(~COL), 1);
    if (!RST_N) begin
      sc_prev = COL; sc_run = 0; sc_skip = 1'b1;
    end else if (COL == sc_prev) begin
      sc_run++;
    end else begin
      chk("col_order", COL, {sc_prev[2:0], sc_prev[3]});
      if (!sc_skip) chk("col_dwell", sc_run, SD);
      sc_skip = 1'b0; sc_run = 1; sc_prev = COL;
    end
  end

  task automatic frame_start();
    int n = 0;
    while (COL != 4'b0111 && n < 40) begin @(negedge CK); n++; end
    while (COL != 4'b1110 && n < 40) begin @(negedge CK); n++; end
    if (n >= 40) chk("frame_start_timeout", n, 0);
  endtask

  task automatic wait_empty(input int lim, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < lim) begin @(negedge CK); n++; end
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic press_release(input logic [15:0] k, input logic [7:0] code, input string name);
    frame_start(); keys = k; exp_q.push_back(code);
    wait_empty(24, name);
    frame_start(); keys = 16'd0; exp_q.push_back(8'd0);
    wait_empty(24, {name, "_rel"});
  endtask

  initial begin
    RST_N = 1'b0;
    keys  = 16'd0;
    #2;
    chk("rst_col", COL, 4'b1110);
    chk("rst_key", KEY, 0);
    chk("rst_evt", KEY_EVENT, 0);
    chk("rst_press", PRESS, 0);
    @(negedge CK); @(negedge CK);
    RST_N = 1'b1;

    // Single key 12 (row 2, column 3)
    press_release(kb(12), 8'd12, "single12");

    // Bounce: key 4 toggled every frame
    for (int i = 0; i < 6; i++) begin
      frame_start();
      keys = (i % 2 == 0) ? kb(4) : 16'd0;
    end
    repeat (3 * 4 * SD) @(negedge CK);
    chk("bounce_key", KEY, 0);

    // Multi-key: lowest code wins
    press_release(kb(6) | kb(11), 8'd6, "multi6_11");
    // Lower row found in a later column still wins
    press_release(kb(9) | kb(2), 8'd2, "multi2_9");
    // Highest code and top-left corner
    press_release(kb(16), 8'd16, "single16");
    press_release(kb(1), 8'd1, "single1");

    // Direct change 12 -> 4 with no release gap
    frame_start(); keys = kb(12); exp_q.push_back(8'd12);
    wait_empty(24, "direct12");
    frame_start(); keys = kb(4); exp_q.push_back(8'd4);
    wait_empty(24, "direct4");
    frame_start(); keys = 16'd0; exp_q.push_back(8'd0);
    wait_empty(24, "direct_rel");

    // Asynchronous reset mid-scan with key held
    frame_start(); keys = kb(12); exp_q.push_back(8'd12);
    wait_empty(24, "prereset12");
    repeat (3) @(negedge CK);
    exp_q.push_back(8'd0);
    #2 RST_N = 1'b0;
    #1;
    chk("async_rst_col", COL, 4'b1110);
    chk("async_rst_key", KEY, 0);
    chk("async_rst_evt", KEY_EVENT, 0);
    @(negedge CK); @(negedge CK);
    #2 RST_N = 1'b1;
    exp_q.push_back(8'd12);
    wait_empty(26, "postreset12");
    frame_start(); keys = 16'd0; exp_q.push_back(8'd0);
    wait_empty(24, "postreset_rel");

    // Long idle scan
    repeat (100 * 4 * SD) @(negedge CK);
    chk("final_key", KEY, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4: clock cycles each column is driven, range 2..255.
REQ-002 SHALL have parameter DEBOUNCE, default 3: consecutive agreeing frames needed to change KEY, range 1..15.
REQ-003 SHALL have port CK  input  1  single system clock; all state changes on rising edge.
REQ-004 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ROW  input  4  matrix row lines, active-low, externally pulled up.
REQ-006 SHALL have port COL  output  4  matrix column drive, active-low, exactly one bit low at all times.
REQ-007 SHALL have port KEY  output  8  debounced key code, 0 = no key; drives the CPU keypad input.
REQ-008 SHALL have port KEY_EVENT  output  1  high exactly when KEY != 0.
REQ-009 SHALL have port PRESS  output  1  one-cycle pulse on each change of KEY to a nonzero value.

Function
REQ-010 SHALL scan columns 0,1,2,3 cyclically, driving COL[c] low for SCAN_DIV cycles per column; one pass of four columns is one frame of 4*SCAN_DIV cycles.
REQ-011 SHALL sample ROW once per column, on the last cycle of that column's dwell, so that SCAN_DIV-1 settling cycles precede each sample.
REQ-012 SHALL encode a low ROW[r] sampled while column c is driven as code 4*r+c+1, giving range 1..16.
REQ-013 SHALL report the lowest code detected in a frame as the frame result when several keys are pressed, and 0 when none is pressed.
REQ-014 SHALL evaluate the frame result at the column-3 sample edge: equal to the held candidate -> increment agree count (saturating at DEBOUNCE); different -> candidate <= result, count <= 1.
REQ-015 SHALL load KEY <= candidate on the edge where the count equals DEBOUNCE and KEY != candidate; KEY SHALL otherwise hold.
REQ-016 SHALL apply the same debounce rule to release (candidate 0), so KEY returns to 0 only after DEBOUNCE agreeing empty frames.
REQ-017 SHALL change KEY directly between two nonzero codes (e.g. 12 -> 4) without forcing an intermediate 0, and SHALL pulse PRESS for that change.
REQ-018 SHALL register KEY_EVENT and PRESS so that both change on the same edge as KEY.
REQ-019 SHALL treat a key pressed or released mid-frame as part of the current frame only from its first sampled column onward; partial frames SHALL reset the agree count per REQ-014.
REQ-020 SHALL hold the column counter and dwell counter to exact widths; after column 3 the scan SHALL wrap to column 0 with no idle cycle.
REQ-021 SHALL give latency from a stable press (held since before frame start) to KEY valid of at most (DEBOUNCE+1)*4*SCAN_DIV cycles.

Reset
REQ-022 SHALL, while RST_N is low, force COL=4'b1110, KEY=0, KEY_EVENT=0, PRESS=0, candidate=0, agree count=0, and dwell counter=0, independent of CK.
REQ-023 SHALL, on RST_N rising, start a fresh frame at column 0; reset asserted mid-frame or mid-debounce SHALL discard all partial results.

Verification
REQ-024 SHALL pass reset: RST_N low mid-scan with key 12 held and KEY=12 -> COL=1110 and KEY=0 immediately without a clock edge; after release, KEY=12 again within (DEBOUNCE+1) frames.
REQ-025 SHALL pass single key: SCAN_DIV=2, DEBOUNCE=2, ROW[2] low only while COL[3] low -> KEY=12, KEY_EVENT=1, one PRESS pulse, within 24 cycles; release -> KEY=0 within 24 cycles, no PRESS.
REQ-026 SHALL pass bounce: key 4 (ROW[0] at COL[3]) toggled every frame for 6 frames -> KEY stays 0 and PRESS never asserts.
REQ-027 SHALL pass multi-key: keys 6 and 11 held together -> KEY=6.
REQ-028 SHALL pass direct change: key 12 held until KEY=12, then key 4 held with no release gap -> KEY goes 12 -> 4 with no intermediate 0 and one PRESS pulse per change.
REQ-029 SHALL pass scan check: over 100 frames, COL always has exactly one zero bit, cycles 1110,1101,1011,0111, with each value lasting SCAN_DIV cycles.
